// File: rtl/flag_cond_unit.sv
// flag_cond_unit: latches the ALU NZVC flags and resolves LEGv8 branches
// (B.cond, CBZ, CBNZ, B) into a registered taken/not-taken pulse. A B.cond
// that depends on flags being written in the same cycle either uses the live
// ALU flags (FORWARD = 1) or stalls one cycle and re-evaluates (FORWARD = 0).
module flag_cond_unit #(
    parameter bit FORWARD = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_negative,
    input  logic       alu_zero,
    input  logic       alu_overflow,
    input  logic       alu_carry_out,
    input  logic       ex_valid,
    input  logic       set_flags,
    input  logic       br_valid,
    input  logic [1:0] br_type,
    input  logic [3:0] br_cond,
    input  logic       cb_zero,
    input  logic       flush,
    output logic       stall,
    output logic       br_resolved,
    output logic       br_taken,
    output logic [3:0] flags_q
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Condition codes come in complementary pairs: cond[3:1] picks the base
    // test, cond[0] inverts it. Codes 14 and 15 are both "always".
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
        logic n;
        logic z;
        logic v;
        logic c;
        logic base;
        n = f[3];
        z = f[2];
        v = f[1];
        c = f[0];
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (cond[3:1] == 3'd7) begin
            return 1'b1;
        end else begin
            return base ^ cond[0];
        end
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] flags_r;
    logic       br_resolved_r;
    logic       br_taken_r;
    logic [3:0] alu_flags_s;
    logic [3:0] eval_flags_s;
    logic       flag_wr_s;
    logic       hz_s;
    logic       outcome_s;
    logic       stall_s;
    logic       res_nxt_s;
    logic       taken_nxt_s;

    assign alu_flags_s = {alu_negative, alu_zero, alu_overflow, alu_carry_out};
    assign flag_wr_s   = ex_valid & set_flags;
    assign hz_s        = br_valid & (br_type == 2'b00) & flag_wr_s;

    // Pick the flag source: live ALU flags only for a forwarded hazard.
    always_comb begin
        eval_flags_s = flags_r;
        if (FORWARD && hz_s && (state_r == IDLE)) begin
            eval_flags_s = alu_flags_s;
        end else begin
            eval_flags_s = flags_r;
        end
    end

    // Branch outcome for the presented branch type.
    always_comb begin
        outcome_s = 1'b0;
        case (br_type)
            2'b00:   outcome_s = cond_eval(br_cond, eval_flags_s);
            2'b01:   outcome_s = cb_zero;
            2'b10:   outcome_s = ~cb_zero;
            2'b11:   outcome_s = 1'b1;
            default: outcome_s = 1'b0;
        endcase
    end

    // Next-state, stall and next resolution; flush overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        stall_s     = 1'b0;
        res_nxt_s   = 1'b0;
        taken_nxt_s = 1'b0;
        if (flush) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!FORWARD && hz_s) begin
                        stall_s     = 1'b1;
                        state_nxt_s = HOLD;
                    end else if (br_valid) begin
                        res_nxt_s   = 1'b1;
                        taken_nxt_s = outcome_s;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                HOLD: begin
                    // A missing re-presentation drops the held branch.
                    state_nxt_s = IDLE;
                    if (br_valid) begin
                        res_nxt_s   = 1'b1;
                        taken_nxt_s = outcome_s;
                    end else begin
                        res_nxt_s   = 1'b0;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Architectural flag register; flush never blocks an older flag write.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_r <= 4'b0000;
        end else if (flag_wr_s) begin
            flags_r <= alu_flags_s;
        end
    end

    // FSM state and registered resolution pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            br_resolved_r <= 1'b0;
            br_taken_r    <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            br_resolved_r <= res_nxt_s;
            br_taken_r    <= res_nxt_s & taken_nxt_s;
        end
    end

    assign stall       = stall_s;
    assign br_resolved = br_resolved_r;
    assign br_taken    = br_taken_r;
    assign flags_q     = flags_r;

endmodule
